// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: shared types for the tiny ALU.
//   operation_t : 3-bit opcode as presented on the op port.
//   state_t     : control FSM state (IDLE, MUL).
package tinyalu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  localparam int MUL_STAGES_DEFAULT = 3;

endpackage

// File: rtl/tinyalu_mult.sv
// tinyalu_mult: registered 8x8 unsigned multiplier with a valid shift chain.
// The top's result register is the last multiply stage, so this block holds
// MUL_STAGES-1 register stages. The product is formed at the first stage and
// then carried through the rest of the chain.
// Ports:
//   clk       : system clock
//   reset_n   : asynchronous active-low reset, clears valid bits and data
//   in_valid  : multiply accepted this cycle (a, b are sampled)
//   a, b      : unsigned byte operands
//   out_valid : product available for the final (result) register
//   product   : 16-bit unsigned product
module tinyalu_mult #(
  parameter int MUL_STAGES = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  output logic [15:0] product
);

  localparam int DEPTH = MUL_STAGES - 1;

  if (MUL_STAGES < 2) begin : g_bad_stages
    $error("tinyalu_mult: MUL_STAGES must be >= 2");
  end

  logic [15:0]      pipe [DEPTH];
  logic [DEPTH-1:0] vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      vld[0]  <= in_valid;
      pipe[0] <= 16'(a) * 16'(b);
      for (int i = 1; i < DEPTH; i++) begin
        vld[i]  <= vld[i-1];
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign product   = pipe[DEPTH-1];

endmodule

// File: rtl/tinyalu.sv
// tinyalu: 8-bit ALU with a level-sensitive start / one-cycle done handshake.
// add/and/xor complete at the accepting edge; mul completes MUL_STAGES edges
// after acceptance (accepting edge counts as the first).
// Handshake: an op is accepted at a rising edge when start=1, the FSM is
// IDLE, the registered done is 0 and op is add/and/xor/mul. done pulses for
// exactly one cycle per accepted op; since done blocks acceptance, a start
// still held during the done cycle cannot retrigger.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset, aborts any operation
//   A, B    : unsigned byte operands, stable while start is high
//   op      : opcode (see tinyalu_pkg::operation_t)
//   start   : request, held until done is seen
//   done    : one-cycle completion pulse
//   result  : result of the last completed operation (held otherwise)
module tinyalu
  import tinyalu_pkg::*;
#(
  parameter int MUL_STAGES = MUL_STAGES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result
);

  state_t      state;
  state_t      state_next;
  logic        single_op;
  logic [15:0] single_result;
  logic        accept;
  logic        mul_accept;
  logic        mul_valid;
  logic [15:0] mul_product;

  // Single-cycle datapath; unused opcodes leave single_op low.
  always_comb begin
    single_op     = 1'b0;
    single_result = '0;
    case (op)
      add_op: begin
        single_op     = 1'b1;
        single_result = 16'(A) + 16'(B);
      end
      and_op: begin
        single_op     = 1'b1;
        single_result = {8'h00, A & B};
      end
      xor_op: begin
        single_op     = 1'b1;
        single_result = {8'h00, A ^ B};
      end
      default: ;
    endcase
  end

  assign accept     = start && (state == IDLE) && !done && (single_op || (op == mul_op));
  assign mul_accept = accept && (op == mul_op);

  tinyalu_mult #(
    .MUL_STAGES(MUL_STAGES)
  ) u_mult (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (mul_accept),
    .a        (A),
    .b        (B),
    .out_valid(mul_valid),
    .product  (mul_product)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul_accept) state_next = MUL;
      MUL:     if (mul_valid)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The result register doubles as the final multiply stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (accept && single_op) begin
        result <= single_result;
        done   <= 1'b1;
      end else if (state == MUL && mul_valid) begin
        result <= mul_product;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tinyalu.sv
// tb_tinyalu: self-checking bench for tinyalu.
module tb_tinyalu;

  localparam int MUL_STAGES = 3;
  localparam int TIMEOUT    = 20;

  logic        clk;
  logic        reset_n;
  logic [7:0]  a_r;
  logic [7:0]  b_r;
  logic [2:0]  op_r;
  logic        start;
  logic        done;
  logic [15:0] result;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_res;

  tinyalu #(.MUL_STAGES(MUL_STAGES)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .A      (a_r),
    .B      (b_r),
    .op     (op_r),
    .start  (start),
    .done   (done),
    .result (result)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: plain arithmetic on unsigned operands
  function automatic logic [15:0] model_result(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int unsigned x, y;
    x = a;
    y = b;
    case (o)
      3'b001:  return 16'(x + y);
      3'b010:  return 16'(x & y);
      3'b011:  return 16'(x ^ y);
      3'b100:  return 16'(x * y);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] o);
    return (o == 3'b100) ? MUL_STAGES : 1;
  endfunction

  // driver: raise start at a falling edge, wait for done at falling edges.
  // tail 0: drop start at done, return.
  // tail 1: drop start, sample done at next falling edge.
  // tail 2: keep start one more cycle, sample done, then drop start.
  task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input int tail, output int cyc, output logic [15:0] res,
                       output logic done_after);
    op_r  = o;
    a_r   = a;
    b_r   = b;
    start = 1'b1;
    cyc   = -1;
    res   = 'x;
    done_after = 1'b0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = i;
        res = result;
        break;
      end
    end
    if (tail != 2) start = 1'b0;
    if (tail != 0) begin
      @(negedge clk);
      done_after = done;
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    op_r    = 3'b000;
    a_r     = '0;
    b_r     = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: done=%b result=%h required done=0 result=0000", done, result);
    end
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [2:0]  ops [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b100};
    logic [7:0]  as  [5] = '{8'hFF, 8'hF0, 8'hAA, 8'hFF, 8'h00};
    logic [7:0]  bs  [5] = '{8'h01, 8'h3C, 8'hFF, 8'hFF, 8'h7B};
    logic [15:0] req [5] = '{16'h0100, 16'h0030, 16'h0055, 16'hFE01, 16'h0000};
    int cyc;
    logic [15:0] res;
    logic da;
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], as[i], bs[i], 1, cyc, res, da);
      checks++;
      if (cyc != model_latency(ops[i]) || res !== req[i]) begin
        errors++;
        $display("FAIL directed_%0d: latency=%0d result=%h required latency=%0d result=%h",
                 i, cyc, res, model_latency(ops[i]), req[i]);
      end
      checks++;
      if (da !== 1'b0) begin
        errors++;
        $display("FAIL directed_%0d_done_pulse: done after pulse=%b required 0", i, da);
      end
    end
  endtask

  task automatic test_noop();
    logic [2:0] codes [4] = '{3'b000, 3'b101, 3'b110, 3'b111};
    int cyc;
    logic [15:0] res;
    logic da;
    do_op(3'b001, 8'hFF, 8'h01, 1, cyc, res, da);
    for (int k = 0; k < 4; k++) begin
      op_r  = codes[k];
      a_r   = 8'h12;
      b_r   = 8'h34;
      start = 1'b1;
      repeat (2) begin
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== 16'h0100) begin
          errors++;
          $display("FAIL noop_%b: done=%b result=%h required done=0 result=0100", codes[k], done, result);
        end
      end
      start = 1'b0;
    end
  endtask

  task automatic test_reset_mid_mul();
    int cyc;
    logic [15:0] res;
    logic da;
    bit seen;
    do_op(3'b001, 8'h10, 8'h20, 1, cyc, res, da);
    op_r  = 3'b100;
    a_r   = 8'hFF;
    b_r   = 8'hFF;
    start = 1'b1;
    @(negedge clk);  // accepting edge has passed; now in the second cycle
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || result !== 16'h0000) begin
      errors++;
      $display("FAIL reset_async: done=%b result=%h required done=0 result=0000", done, result);
    end
    start = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || result !== 16'h0000) begin
      errors++;
      $display("FAIL reset_abort: late done=%b result=%h required done=0 result=0000", seen, result);
    end
    do_op(3'b001, 8'h02, 8'h03, 1, cyc, res, da);
    checks++;
    if (cyc != 1 || res !== 16'h0005) begin
      errors++;
      $display("FAIL reset_recover: latency=%0d result=%h required latency=1 result=0005", cyc, res);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [15:0] res;
    logic da;
    // start held through the done cycle must not retrigger
    do_op(3'b001, 8'h40, 8'h41, 2, cyc, res, da);
    checks++;
    if (cyc != 1 || res !== 16'h0081 || da !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overlap: latency=%0d result=%h done_next=%b required 1 0081 0", cyc, res, da);
    end
    // add then mul raised in the add's done cycle: mul is accepted one edge later
    do_op(3'b001, 8'h05, 8'h06, 0, cyc, res, da);
    checks++;
    if (cyc != 1 || res !== 16'h000B) begin
      errors++;
      $display("FAIL b2b_add: latency=%0d result=%h required latency=1 result=000b", cyc, res);
    end
    do_op(3'b100, 8'h0C, 8'h0D, 1, cyc, res, da);
    checks++;
    if (cyc != MUL_STAGES + 1 || res !== 16'h009C || da !== 1'b0) begin
      errors++;
      $display("FAIL b2b_mul: latency=%0d result=%h done_next=%b required %0d 009c 0",
               cyc, res, da, MUL_STAGES + 1);
    end
  endtask

  task automatic test_random();
    logic [2:0] valid_ops [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
    logic [2:0] idle_ops  [4] = '{3'b000, 3'b101, 3'b110, 3'b111};
    logic [2:0] o;
    logic [7:0] a, b;
    logic [15:0] exp;
    int cyc;
    logic [15:0] res;
    logic da;
    for (int n = 0; n < 40; n++) begin
      o = valid_ops[$urandom_range(0, 3)];
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(model_result(o, a, b));
      do_op(o, a, b, 1, cyc, res, da);
      exp = exp_q.pop_front();
      last_res = exp;
      checks++;
      if (cyc != model_latency(o) || res !== exp || da !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d op=%b a=%h b=%h: latency=%0d result=%h done_next=%b required %0d %h 0",
                 n, o, a, b, cyc, res, da, model_latency(o), exp);
      end
      if ($urandom_range(0, 3) == 0) begin
        op_r  = idle_ops[$urandom_range(0, 3)];
        a_r   = 8'($urandom_range(0, 255));
        b_r   = 8'($urandom_range(0, 255));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || result !== last_res) begin
          errors++;
          $display("FAIL random_hold_%0d: done=%b result=%h required done=0 result=%h",
                   n, done, result, last_res);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_noop();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
